alu_result_drain: RTL and testbench

ALU_RESULT_DRAIN -- requirements
Module: alu_result_drain

---
 rtl/alu_result_drain.sv | 93 +++++++++
 tb/tb_alu_result_drain.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_result_drain.sv
// Drains a 64-bit ALU C result onto a 32-bit register bus as one LO beat, or LO then HI for multiply/divide.
// Optional zero flag is built only when ALU_RESULT_DRAIN_ZERO_FLAG_EN is defined.
module alu_result_drain #(
  parameter logic [4:0] OP_MUL = 5'b10011,
  parameter logic [4:0] OP_DIV = 5'b10100
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [4:0]  opcode,
  input  logic [63:0] c_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_hi,
  output logic        zero
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SEND_LO = 2'd1,
    SEND_HI = 2'd2
  } state_t;

  state_t      r_state;
  logic [63:0] r_hold;
  logic        r_two_beat;

  logic w_two_beat_op;
  logic w_final_beat;
  logic w_in_xfer;
  logic w_out_xfer;

  assign w_two_beat_op = (opcode == OP_MUL) || (opcode == OP_DIV);
  // The hold register frees up in the same cycle its last beat leaves, so a new result can follow with no bubble.
  assign w_final_beat  = ((r_state == SEND_LO) && !r_two_beat) || (r_state == SEND_HI);
  assign in_ready      = !clr && ((r_state == IDLE) || (w_final_beat && out_ready));
  assign w_in_xfer     = in_valid && in_ready;

  assign out_valid  = (r_state == SEND_LO) || (r_state == SEND_HI);
  assign out_hi     = (r_state == SEND_HI);
  assign out_data   = (r_state == SEND_HI) ? r_hold[63:32] : r_hold[31:0];
  assign w_out_xfer = out_valid && out_ready;

  // NOTE: non-blocking assignments so every register samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (clr) begin
      r_state    <= IDLE;
      r_hold     <= '0;
      r_two_beat <= 1'b0;
    end else begin
      if (w_in_xfer) begin
        // Single-beat results never emit HI, so their upper word is not kept.
        r_hold     <= {(w_two_beat_op ? c_in[63:32] : 32'h0), c_in[31:0]};
        r_two_beat <= w_two_beat_op;
      end
      unique case (r_state)
        IDLE: begin
          if (w_in_xfer) r_state <= SEND_LO;
        end
        SEND_LO: begin
          if (w_out_xfer) begin
            if (r_two_beat)     r_state <= SEND_HI;
            else if (w_in_xfer) r_state <= SEND_LO;
            else                r_state <= IDLE;
          end
        end
        SEND_HI: begin
          if (w_out_xfer) r_state <= w_in_xfer ? SEND_LO : IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef ALU_RESULT_DRAIN_ZERO_FLAG_EN
  logic r_zero;

  always_ff @(posedge clk) begin
    if (clr) begin
      r_zero <= 1'b0;
    end else if (w_in_xfer) begin
      r_zero <= w_two_beat_op ? (c_in == 64'h0) : (c_in[31:0] == 32'h0);
    end
  end

  assign zero = r_zero;
`else
  assign zero = 1'b0;
`endif

endmodule

// File: tb/tb_alu_result_drain.sv
// Self-checking bench for alu_result_drain: directed vector table, hand sequences for clear/zero,
// then randomized traffic against a beat-queue reference model.
module tb_alu_result_drain;

  localparam logic [4:0] OP_MUL = 5'b10011;
  localparam logic [4:0] OP_DIV = 5'b10100;

  logic        clk;
  logic        clr;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  opcode;
  logic [63:0] c_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_hi;
  logic        zero;

  int checks = 0;
  int errors = 0;

  alu_result_drain dut (
    .clk       (clk),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .opcode    (opcode),
    .c_in      (c_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_hi    (out_hi),
    .zero      (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        clr;
    logic        iv;
    logic [4:0]  op;
    logic [63:0] c;
    logic        ordy;
    logic        e_ov;
    logic [31:0] e_data;
    logic        e_hi;
    logic        e_ir;
  } vec_t;

  typedef struct {
    logic [31:0] data;
    logic        hi;
  } beat_t;

  vec_t  vq[$];
  beat_t mq[$];
  logic  m_zero;

  function automatic vec_t mk(input logic cl, input logic iv, input logic [4:0] op,
                              input logic [63:0] c, input logic ordy, input logic e_ov,
                              input logic [31:0] e_data, input logic e_hi, input logic e_ir);
    vec_t v;
    v.clr = cl; v.iv = iv; v.op = op; v.c = c; v.ordy = ordy;
    v.e_ov = e_ov; v.e_data = e_data; v.e_hi = e_hi; v.e_ir = e_ir;
    return v;
  endfunction

  function automatic logic zero_of(input logic [4:0] op, input logic [63:0] c);
`ifdef ALU_RESULT_DRAIN_ZERO_FLAG_EN
    if (op == OP_MUL || op == OP_DIV) return (c == 64'h0);
    return (c[31:0] == 32'h0);
`else
    return 1'b0;
`endif
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs mid-period; outputs are then sampled well away from the rising edge.
  task automatic apply(input logic cl, input logic iv, input logic [4:0] op,
                       input logic [63:0] c, input logic ordy);
    @(negedge clk);
    clr = cl; in_valid = iv; opcode = op; c_in = c; out_ready = ordy;
    #1;
  endtask

  initial begin
    logic exp_ir;
    logic [63:0] rc;
    logic [4:0]  rop;
    beat_t b;

    clr = 1'b1; in_valid = 1'b0; opcode = '0; c_in = '0; out_ready = 1'b0;
    apply(1'b1, 1'b0, 5'd0, 64'h0, 1'b0);

    // ---------------- directed vector table ----------------
    vq.push_back(mk(1, 1, 5'h11, 64'h1234,                1, 0, 32'h0,         0, 0));
    vq.push_back(mk(0, 0, 5'h11, 64'h0,                   1, 0, 32'h0,         0, 1));
    vq.push_back(mk(0, 1, 5'h11, 64'hFFFF_FFFF_0000_0005, 1, 0, 32'h0,         0, 1));
    vq.push_back(mk(0, 0, 5'h11, 64'h0,                   1, 1, 32'h5,         0, 1));
    vq.push_back(mk(0, 0, 5'h11, 64'h0,                   1, 0, 32'h0,         0, 1));
    vq.push_back(mk(0, 1, OP_MUL, 64'h0000_0001_8000_0000, 1, 0, 32'h0,        0, 1));
    vq.push_back(mk(0, 0, 5'h00, 64'h0,                   1, 1, 32'h8000_0000, 0, 0));
    vq.push_back(mk(0, 0, 5'h00, 64'h0,                   1, 1, 32'h1,         1, 1));
    vq.push_back(mk(0, 0, 5'h00, 64'h0,                   1, 0, 32'h0,         0, 1));
    vq.push_back(mk(0, 1, OP_DIV, 64'h3_0000_0007,        0, 0, 32'h0,         0, 1));
    for (int i = 0; i < 5; i++)
      vq.push_back(mk(0, 0, 5'h00, 64'h0,                 0, 1, 32'h7,         0, 0));
    vq.push_back(mk(0, 0, 5'h00, 64'h0,                   1, 1, 32'h7,         0, 0));
    vq.push_back(mk(0, 0, 5'h00, 64'h0,                   1, 1, 32'h3,         1, 1));
    vq.push_back(mk(0, 0, 5'h00, 64'h0,                   1, 0, 32'h0,         0, 1));
    vq.push_back(mk(0, 1, 5'h11, 64'h0000_0000_0000_000A, 1, 0, 32'h0,         0, 1));
    vq.push_back(mk(0, 1, 5'h11, 64'h0000_0000_0000_000B, 1, 1, 32'hA,         0, 1));
    vq.push_back(mk(0, 0, 5'h11, 64'h0,                   1, 1, 32'hB,         0, 1));
    vq.push_back(mk(0, 0, 5'h11, 64'h0,                   1, 0, 32'h0,         0, 1));
    vq.push_back(mk(0, 1, OP_MUL, 64'h0000_0002_0000_0001, 1, 0, 32'h0,        0, 1));
    vq.push_back(mk(0, 0, 5'h00, 64'h0,                   1, 1, 32'h1,         0, 0));
    vq.push_back(mk(0, 1, 5'h01, 64'h5555_5555_0000_000C, 1, 1, 32'h2,         1, 1));
    vq.push_back(mk(0, 0, 5'h00, 64'h0,                   1, 1, 32'hC,         0, 1));
    vq.push_back(mk(0, 0, 5'h00, 64'h0,                   1, 0, 32'h0,         0, 1));
    vq.push_back(mk(0, 1, 5'h00, 64'h0000_0000_0000_000D, 0, 0, 32'h0,         0, 1));
    vq.push_back(mk(0, 1, 5'h00, 64'h0000_0000_0000_000E, 0, 1, 32'hD,         0, 0));
    vq.push_back(mk(0, 0, 5'h00, 64'h0,                   1, 1, 32'hD,         0, 1));
    vq.push_back(mk(0, 0, 5'h00, 64'h0,                   1, 0, 32'h0,         0, 1));

    foreach (vq[i]) begin
      apply(vq[i].clr, vq[i].iv, vq[i].op, vq[i].c, vq[i].ordy);
      check($sformatf("vec%0d out_valid", i), {63'h0, out_valid}, {63'h0, vq[i].e_ov});
      check($sformatf("vec%0d in_ready", i), {63'h0, in_ready}, {63'h0, vq[i].e_ir});
      if (vq[i].e_ov) begin
        check($sformatf("vec%0d out_data", i), {32'h0, out_data}, {32'h0, vq[i].e_data});
        check($sformatf("vec%0d out_hi", i), {63'h0, out_hi}, {63'h0, vq[i].e_hi});
      end
    end

    // ---------------- clear during SEND_HI, then zero flag ----------------
    apply(0, 1, OP_MUL, 64'hAAAA_5555_1234_5678, 1);
    apply(0, 0, 5'h00, 64'h0, 1);
    check("clrseq lo beat", {32'h0, out_data}, 64'h1234_5678);
    apply(1, 1, 5'h01, 64'h9, 1);
    check("clrseq hi pending", {62'h0, out_valid, out_hi}, 64'h3);
    check("clrseq in_ready during clr", {63'h0, in_ready}, 64'h0);
    apply(0, 0, 5'h00, 64'h0, 1);
    check("clrseq out_valid after clr", {63'h0, out_valid}, 64'h0);
    check("clrseq zero after clr", {63'h0, zero}, 64'h0);
    check("clrseq in_ready after clr", {63'h0, in_ready}, 64'h1);
    apply(0, 0, 5'h00, 64'h0, 1);
    check("clrseq no late beat", {63'h0, out_valid}, 64'h0);

    apply(0, 1, 5'h00, 64'hFFFF_FFFF_0000_0000, 1);
    apply(0, 0, 5'h00, 64'h0, 1);
    check("zero single lo==0", {63'h0, zero}, {63'h0, zero_of(5'h00, 64'hFFFF_FFFF_0000_0000)});
    check("zero single beat data", {31'h0, out_hi, out_data}, 64'h0);
    apply(0, 1, OP_DIV, 64'h0000_0001_0000_0000, 1);
    apply(0, 0, 5'h00, 64'h0, 1);
    check("zero twobeat nonzero", {63'h0, zero}, 64'h0);
    apply(0, 0, 5'h00, 64'h0, 1);
    check("zero twobeat hi beat", {31'h0, out_hi, out_data}, 64'h1_0000_0001);
    apply(0, 0, 5'h00, 64'h0, 1);

    // ---------------- randomized traffic vs beat-queue model ----------------
    apply(1, 0, 5'h00, 64'h0, 0);
    mq.delete();
    m_zero = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      rc = {$urandom, $urandom};
      if ($urandom_range(0, 7) == 0)  rc[31:0] = 32'h0;
      if ($urandom_range(0, 15) == 0) rc = 64'h0;
      case ($urandom_range(0, 3))
        0:       rop = OP_MUL;
        1:       rop = OP_DIV;
        default: rop = 5'($urandom);
      endcase
      apply(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) != 0), rop, rc,
            ($urandom_range(0, 2) != 0));

      // The block holds one result; it takes another only once nothing would remain after this cycle.
      exp_ir = !clr && (mq.size() == 0 || (mq.size() == 1 && out_ready));
      check("rnd out_valid", {63'h0, out_valid}, {63'h0, (mq.size() != 0)});
      check("rnd in_ready", {63'h0, in_ready}, {63'h0, exp_ir});
      check("rnd zero", {63'h0, zero}, {63'h0, m_zero});
      if (mq.size() != 0) begin
        check("rnd beat", {31'h0, out_hi, out_data}, {31'h0, mq[0].hi, mq[0].data});
      end

      if (clr) begin
        mq.delete();
        m_zero = 1'b0;
      end else begin
        if (mq.size() != 0 && out_ready) void'(mq.pop_front());
        if (in_valid && exp_ir) begin
          b.data = c_in[31:0]; b.hi = 1'b0;
          mq.push_back(b);
          if (opcode == OP_MUL || opcode == OP_DIV) begin
            b.data = c_in[63:32]; b.hi = 1'b1;
            mq.push_back(b);
          end
          m_zero = zero_of(opcode, c_in);
        end
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
